// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch status encodings and defaults
package stopwatch_pkg;

  // Control FSM state as reported on the status bus
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debouncer and press detector
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = stopwatch_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = stopwatch_pkg::DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Bring the asynchronous button level into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples;
  // the press pulse is raised in the same edge that the level goes 0->1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_s2 != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db    <= r_s2;
          r_cnt   <= '0;
          r_press <= r_s2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/button_cmd_gen.sv
// rtl/button_cmd_gen.sv - maps debounced button presses onto stopwatch commands
module button_cmd_gen
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_startstop_raw,
  input  logic       btn_reset_raw,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset
);

  logic    w_ss_press;
  logic    w_rst_press;
  status_e w_status;
  logic    w_start_nxt;
  logic    w_stop_nxt;
  logic    w_reset_nxt;
  logic    r_start;
  logic    r_stop;
  logic    r_reset;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ss_db (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (btn_startstop_raw),
    .o_press(w_ss_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rst_db (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (btn_reset_raw),
    .o_press(w_rst_press)
  );

  assign w_status = status_e'(status);

  // Reset press wins outright; the toggle press becomes start or stop from current status
  always_comb begin
    w_start_nxt = 1'b0;
    w_stop_nxt  = 1'b0;
    w_reset_nxt = 1'b0;
    if (w_rst_press) begin
      w_reset_nxt = 1'b1;
    end else if (w_ss_press) begin
      case (w_status)
        ST_IDLE, ST_PAUSED: w_start_nxt = 1'b1;
        ST_RUNNING:         w_stop_nxt  = 1'b1;
        default:            ;
      endcase
    end
  end

  // Registered one-hot command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_reset <= 1'b0;
    end else begin
      r_start <= w_start_nxt;
      r_stop  <= w_stop_nxt;
      r_reset <= w_reset_nxt;
    end
  end

  assign start = r_start;
  assign stop  = r_stop;
  assign reset = r_reset;

endmodule

// File: tb/tb_button_cmd_gen.sv
// tb/tb_button_cmd_gen.sv - directed self-checking bench for button_cmd_gen
module tb_button_cmd_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_startstop_raw = 1'b0;
  logic       btn_reset_raw = 1'b0;
  logic [1:0] status = 2'b00;
  logic       start;
  logic       stop;
  logic       reset;

  int errors = 0;
  int checks = 0;

  int n_start, n_stop, n_reset, f_start, f_stop, f_reset, n_multi;

  always #5 clk = ~clk;

  button_cmd_gen #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .btn_startstop_raw(btn_startstop_raw),
    .btn_reset_raw    (btn_reset_raw),
    .status           (status),
    .start            (start),
    .stop             (stop),
    .reset            (reset)
  );

  // Observe n cycles from a negedge; cycle k is sampled at the negedge after edge k
  task automatic watch(input int n);
    n_start = 0; n_stop = 0; n_reset = 0; n_multi = 0;
    f_start = 0; f_stop = 0; f_reset = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (start) begin n_start++; if (f_start == 0) f_start = k; end
      if (stop)  begin n_stop++;  if (f_stop == 0)  f_stop = k;  end
      if (reset) begin n_reset++; if (f_reset == 0) f_reset = k; end
      if (int'(start) + int'(stop) + int'(reset) > 1) n_multi++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    watch(3);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL reset_outputs: pulses=%0d expected 0", n_start + n_stop + n_reset); end
    checks++; if (u_dut.u_ss_db.r_db !== 1'b0) begin errors++;
      $display("FAIL reset_db: got %b expected 0", u_dut.u_ss_db.r_db); end
    rst = 1'b0;
    watch(1);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL reset_first_cycle: pulses=%0d expected 0", n_start + n_stop + n_reset); end
    watch(5);
  endtask

  task automatic test_start_hold;
    status = 2'b00;
    btn_startstop_raw = 1'b1;
    watch(57);
    checks++; if (n_start !== 1 || f_start !== 7) begin errors++;
      $display("FAIL hold_start: count=%0d first=%0d expected 1 at 7", n_start, f_start); end
    checks++; if (n_stop !== 0 || n_reset !== 0) begin errors++;
      $display("FAIL hold_other: stop=%0d reset=%0d expected 0 0", n_stop, n_reset); end
    btn_startstop_raw = 1'b0;
    watch(20);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL hold_release: pulses=%0d expected 0", n_start + n_stop + n_reset); end
    checks++; if (u_dut.u_ss_db.r_db !== 1'b0) begin errors++;
      $display("FAIL hold_release_db: got %b expected 0", u_dut.u_ss_db.r_db); end
  endtask

  task automatic test_stop_pause;
    status = 2'b01;
    btn_startstop_raw = 1'b1;
    watch(20);
    checks++; if (n_stop !== 1 || f_stop !== 7) begin errors++;
      $display("FAIL running_stop: count=%0d first=%0d expected 1 at 7", n_stop, f_stop); end
    checks++; if (n_start !== 0 || n_reset !== 0) begin errors++;
      $display("FAIL running_other: start=%0d reset=%0d expected 0 0", n_start, n_reset); end
    btn_startstop_raw = 1'b0;
    watch(20);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL running_release: pulses=%0d expected 0", n_start + n_stop + n_reset); end
    status = 2'b10;
    btn_startstop_raw = 1'b1;
    watch(20);
    checks++; if (n_start !== 1 || f_start !== 7) begin errors++;
      $display("FAIL paused_start: count=%0d first=%0d expected 1 at 7", n_start, f_start); end
    checks++; if (n_stop !== 0 || n_reset !== 0) begin errors++;
      $display("FAIL paused_other: stop=%0d reset=%0d expected 0 0", n_stop, n_reset); end
    btn_startstop_raw = 1'b0;
    watch(20);
  endtask

  task automatic test_glitch;
    int total;
    total = 0;
    status = 2'b00;
    for (int i = 0; i < 40; i++) begin
      btn_startstop_raw = ~btn_startstop_raw;
      watch(1);
      total += n_start + n_stop + n_reset;
    end
    btn_startstop_raw = 1'b0;
    watch(4);
    total += n_start + n_stop + n_reset;
    checks++; if (u_dut.u_ss_db.r_db !== 1'b0) begin errors++;
      $display("FAIL toggle_db: got %b expected 0", u_dut.u_ss_db.r_db); end
    for (int p = 0; p < 4; p++) begin
      btn_startstop_raw = 1'b1;
      watch(3);
      total += n_start + n_stop + n_reset;
      btn_startstop_raw = 1'b0;
      watch(3);
      total += n_start + n_stop + n_reset;
    end
    watch(10);
    total += n_start + n_stop + n_reset;
    checks++; if (total !== 0) begin errors++;
      $display("FAIL glitch_pulses: got %0d expected 0", total); end
    checks++; if (u_dut.u_ss_db.r_db !== 1'b0) begin errors++;
      $display("FAIL glitch_db: got %b expected 0", u_dut.u_ss_db.r_db); end
  endtask

  task automatic test_simultaneous;
    status = 2'b01;
    btn_startstop_raw = 1'b1;
    btn_reset_raw = 1'b1;
    watch(20);
    checks++; if (n_reset !== 1 || f_reset !== 7) begin errors++;
      $display("FAIL simul_reset: count=%0d first=%0d expected 1 at 7", n_reset, f_reset); end
    checks++; if (n_stop !== 0 || n_start !== 0) begin errors++;
      $display("FAIL simul_dropped: stop=%0d start=%0d expected 0 0", n_stop, n_start); end
    checks++; if (n_multi !== 0) begin errors++;
      $display("FAIL simul_onehot: got %0d multi-high cycles expected 0", n_multi); end
    btn_startstop_raw = 1'b0;
    btn_reset_raw = 1'b0;
    watch(20);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL simul_release: pulses=%0d expected 0", n_start + n_stop + n_reset); end
  endtask

  task automatic test_rst_mid;
    status = 2'b00;
    btn_reset_raw = 1'b1;
    watch(4);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL midrst_before: pulses=%0d expected 0", n_start + n_stop + n_reset); end
    rst = 1'b1;
    watch(2);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL midrst_during: pulses=%0d expected 0", n_start + n_stop + n_reset); end
    rst = 1'b0;
    watch(15);
    checks++; if (n_reset !== 1 || f_reset !== 7) begin errors++;
      $display("FAIL midrst_after: count=%0d first=%0d expected 1 at 7", n_reset, f_reset); end
    checks++; if (n_start !== 0 || n_stop !== 0) begin errors++;
      $display("FAIL midrst_other: start=%0d stop=%0d expected 0 0", n_start, n_stop); end
    btn_reset_raw = 1'b0;
    watch(20);
  endtask

  task automatic test_illegal_status;
    status = 2'b11;
    btn_startstop_raw = 1'b1;
    watch(20);
    checks++; if (n_start + n_stop + n_reset !== 0) begin errors++;
      $display("FAIL illegal_drop: pulses=%0d expected 0", n_start + n_stop + n_reset); end
    btn_startstop_raw = 1'b0;
    watch(20);
    status = 2'b00;
    btn_startstop_raw = 1'b1;
    watch(20);
    checks++; if (n_start !== 1 || f_start !== 7) begin errors++;
      $display("FAIL illegal_recover: count=%0d first=%0d expected 1 at 7", n_start, f_start); end
    checks++; if (n_stop !== 0 || n_reset !== 0) begin errors++;
      $display("FAIL illegal_other: stop=%0d reset=%0d expected 0 0", n_stop, n_reset); end
    btn_startstop_raw = 1'b0;
    watch(20);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start_hold();
    test_stop_pause();
    test_glitch();
    test_simultaneous();
    test_rst_mid();
    test_illegal_status();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_cmd_gen.md
Name: button_cmd_gen

Overview:
Front-end command generator that drives the stopwatch control FSM's start/stop/reset command inputs from two raw asynchronous push-buttons.
- Synchronises, debounces and edge-detects each button.
- Maps the single start/stop toggle button onto a start or stop pulse, using the FSM's status feedback.
- Emits single-cycle, mutually exclusive command pulses.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronised samples at a new level needed to accept it (legal range 2..2^CNT_W-1).
- CNT_W, 16: debounce counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- btn_startstop_raw  input  1  raw start/stop toggle button, asynchronous, 1 = pressed.
- btn_reset_raw  input  1  raw reset button, asynchronous, 1 = pressed.
- status  input  2  FSM state: 00 = IDLE, 01 = RUNNING, 10 = PAUSED, 11 = illegal.
- start  output  1  one-cycle start command.
- stop  output  1  one-cycle stop/pause command.
- reset  output  1  one-cycle synchronous reset command.

Behaviour:
- rst asserted:
  - All synchroniser flops, debounced levels and counters clear to 0.
  - start, stop and reset are 0 while rst is high and on the first cycle after release.
- Synchroniser: two flops per raw input. s2 reflects a raw level sampled at edge k after edge k+1.
- Debounce (per channel, registered level db, counter cnt):
  - s2 != db: cnt increments.
  - s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2 and cnt <= 0.
  - s2 == db: cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES samples is fully rejected.
  - cnt never wraps.
- Press event: db rising 0->1, valid for exactly one cycle.
  - Release (1->0) is debounced identically but produces no event.
  - A held button produces no repeats.
- Latency: raw held high from sampling edge 1 → db = 1 after edge DEBOUNCE_CYCLES+2 → command output high for the single cycle after edge DEBOUNCE_CYCLES+3.
- Outputs are registered, one-hot or all zero, never two high together.
- Command mapping, evaluated on the cycle of the press event using the current status:
  - Reset press → reset = 1.
  - Start/stop press with status 00 or 10 → start = 1.
  - Start/stop press with status 01 → stop = 1.
  - Start/stop press with status 11 → no output (event dropped).
- Simultaneous press events on both channels in the same cycle → reset only; the start/stop event is dropped, not deferred.
- Status changing in the same cycle as an event: the pre-edge (current) value is used.
- Reset mid-operation:
  - Counters and levels are lost.
  - A button still held when rst deasserts is seen as a fresh press after the full latency, producing one command.
- No state machine beyond the debounce counters. The per-channel pipeline is s1 → s2 → db → pulse register.

Decomposition:
- Shared package stopwatch_pkg:
  - Status encodings ST_IDLE = 2'b00, ST_RUNNING = 2'b01, ST_PAUSED = 2'b10, shared with the control FSM.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module btn_debounce:
  - Contents: synchroniser, debounce counter, db register, rise-pulse output.
  - Parameterised by DEBOUNCE_CYCLES and CNT_W.
  - Instantiated twice.
- Top level holds the command mapping, priority logic and output registers.

Test Plan:
- DEBOUNCE_CYCLES = 4, status = 00, btn_startstop_raw held high from edge 1 → start high exactly during the cycle after edge 7; stop and reset stay 0; no further pulses while held 50 cycles.
- status = 01, clean start/stop press → single stop pulse; release after 20 cycles → no pulse. Repeat with status = 10 → single start pulse.
- Raw start/stop toggling 1,0,1,0 each cycle for 40 cycles, then 3-cycle high pulses → zero commands; debounced level stays 0.
- Both raws rise on the same edge, status = 01 → one reset pulse only; stop never asserted.
- btn_reset_raw held, rst pulsed high 2 cycles at edge 5 (before acceptance) → no output during or after rst; one reset pulse 7 cycles after rst release.
- status = 11, start/stop press → no outputs; then status = 00 with a new press → one start pulse.
